cdb_rs: RTL and testbench

//  Reservation station (RS) for one execution unit (EU); the receiving and sourcing end of the common data bus (CDB).

---
 rtl/expipe_pkg.sv | 29 ++
 rtl/len5_pkg.sv | 7 +
 rtl/cdb_rs_prio_enc.sv | 22 ++
 rtl/cdb_rs.sv | 228 ++++++++++++++++++++++
 tb/tb_cdb_rs.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/expipe_pkg.sv
// Execution-pipeline types shared by reservation stations, the CDB and the ROB.
package expipe_pkg;

    import len5_pkg::*;

    // Width of the opaque control word handed to an execution unit.
    localparam int EU_CTL_LEN  = 8;

    // Width of a reorder-buffer index; producer tags on the CDB use this width.
    localparam int ROB_IDX_LEN = 4;

    // One CDB broadcast: which ROB entry produced it, the value and its exception flag.
    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_idx;
        logic [XLEN-1:0]        value;
        logic                   except_raised;
    } cdb_data_t;

    // Life cycle of one reservation-station entry. EMPTY must stay the zero code
    // so that clearing an entry to all-zero leaves it free.
    typedef enum logic [2:0] {
        EMPTY    = 3'd0,
        WAIT_OPS = 3'd1,
        READY    = 3'd2,
        EXEC     = 3'd3,
        DONE     = 3'd4
    } rs_state_t;

endpackage

// File: rtl/len5_pkg.sv
// Core-wide architectural parameters shared by every pipeline block.
package len5_pkg;

    // Width of an integer register and of every value carried on the CDB.
    localparam int XLEN = 32;

endpackage

// File: rtl/cdb_rs_prio_enc.sv
// Lowest-index set-bit encoder used to pick which RS entry is served first.
module prio_enc #(
    parameter int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cdb_rs.sv
// Reservation station for a single execution unit. Holds issued instructions,
// snoops the CDB for missing operands, dispatches ready work to the EU, parks the
// returned result and offers it to the CDB arbiter.
module cdb_rs
    import len5_pkg::*;
    import expipe_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,

    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [EU_CTL_LEN-1:0]  issue_eu_ctl_i,
    input  logic                   issue_rs1_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs1_idx_i,
    input  logic [XLEN-1:0]        issue_rs1_value_i,
    input  logic                   issue_rs2_ready_i,
    input  logic [ROB_IDX_LEN-1:0] issue_rs2_idx_i,
    input  logic [XLEN-1:0]        issue_rs2_value_i,
    input  logic [ROB_IDX_LEN-1:0] issue_dest_idx_i,

    output logic                   eu_valid_o,
    input  logic                   eu_ready_i,
    output logic [EU_CTL_LEN-1:0]  eu_ctl_o,
    output logic [XLEN-1:0]        eu_rs1_o,
    output logic [XLEN-1:0]        eu_rs2_o,
    output logic [TAG_W-1:0]       eu_tag_o,

    input  logic                   eu_valid_i,
    output logic                   eu_ready_o,
    input  logic [TAG_W-1:0]       eu_tag_i,
    input  logic [XLEN-1:0]        eu_result_i,
    input  logic                   eu_except_raised_i,

    output logic                   cdb_valid_o,
    input  logic                   cdb_ready_i,
    output cdb_data_t              cdb_data_o,

    input  logic                   cdb_valid_i,
    input  cdb_data_t              cdb_data_i
);

    // Everything one entry has to remember between issue and CDB write-back.
    typedef struct packed {
        rs_state_t              state;
        logic [EU_CTL_LEN-1:0]  ctl;
        logic                   rs1_ready;
        logic [ROB_IDX_LEN-1:0] rs1_idx;
        logic [XLEN-1:0]        rs1_value;
        logic                   rs2_ready;
        logic [ROB_IDX_LEN-1:0] rs2_idx;
        logic [XLEN-1:0]        rs2_value;
        logic [ROB_IDX_LEN-1:0] dest_idx;
        logic [XLEN-1:0]        result;
        logic                   except_raised;
    } rs_entry_t;

    rs_entry_t        entry_q [DEPTH];
    rs_entry_t        entry_d [DEPTH];

    logic [DEPTH-1:0] free_mask;
    logic [DEPTH-1:0] ready_mask;
    logic [DEPTH-1:0] done_mask;
    logic [TAG_W-1:0] free_idx;
    logic [TAG_W-1:0] ready_idx;
    logic [TAG_W-1:0] done_idx;
    logic             free_any;
    logic             ready_any;
    logic             done_any;

    logic             issue_fire;
    logic             dispatch_fire;
    logic             grant_fire;

    // The exception flag of a snooped broadcast is irrelevant to operand capture.
    logic             unused_cdb_except;
    assign unused_cdb_except = cdb_data_i.except_raised;

    // Per-entry status vectors, taken from registered state only so that an entry
    // freed this cycle cannot be handed out again until the next one.
    always_comb begin
        free_mask  = '0;
        ready_mask = '0;
        done_mask  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_mask[i]  = (entry_q[i].state == EMPTY);
            ready_mask[i] = (entry_q[i].state == READY);
            done_mask[i]  = (entry_q[i].state == DONE);
        end
    end

    prio_enc #(.N(DEPTH)) u_free_enc (
        .req_i   (free_mask),
        .idx_o   (free_idx),
        .valid_o (free_any)
    );

    prio_enc #(.N(DEPTH)) u_ready_enc (
        .req_i   (ready_mask),
        .idx_o   (ready_idx),
        .valid_o (ready_any)
    );

    prio_enc #(.N(DEPTH)) u_done_enc (
        .req_i   (done_mask),
        .idx_o   (done_idx),
        .valid_o (done_any)
    );

    assign issue_ready_o = free_any;
    assign eu_valid_o    = ready_any;
    assign cdb_valid_o   = done_any;
    assign eu_ready_o    = 1'b1;

    assign issue_fire    = issue_valid_i & free_any;
    assign dispatch_fire = ready_any & eu_ready_i;
    assign grant_fire    = done_any & cdb_ready_i;

    // The oldest-index ready entry feeds the EU; its fields are held in flops, so
    // they cannot change while the EU stalls.
    always_comb begin
        eu_ctl_o = entry_q[ready_idx].ctl;
        eu_rs1_o = entry_q[ready_idx].rs1_value;
        eu_rs2_o = entry_q[ready_idx].rs2_value;
        eu_tag_o = ready_idx;
    end

    // The lowest-index finished entry is offered to the arbiter and stays put
    // until it is granted.
    always_comb begin
        cdb_data_o               = '0;
        cdb_data_o.rob_idx       = entry_q[done_idx].dest_idx;
        cdb_data_o.value         = entry_q[done_idx].result;
        cdb_data_o.except_raised = entry_q[done_idx].except_raised;
    end

    // Next state of every entry; each entry reacts only to the event aimed at its
    // current state, so issue, snoop, dispatch, result and grant coexist in a cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            case (entry_q[i].state)
                EMPTY: begin
                    if (issue_fire && (free_idx == TAG_W'(i))) begin
                        entry_d[i].ctl       = issue_eu_ctl_i;
                        entry_d[i].dest_idx  = issue_dest_idx_i;
                        entry_d[i].rs1_idx   = issue_rs1_idx_i;
                        entry_d[i].rs2_idx   = issue_rs2_idx_i;
                        entry_d[i].rs1_ready = issue_rs1_ready_i;
                        entry_d[i].rs1_value = issue_rs1_value_i;
                        entry_d[i].rs2_ready = issue_rs2_ready_i;
                        entry_d[i].rs2_value = issue_rs2_value_i;
                        if (!issue_rs1_ready_i && cdb_valid_i &&
                            (issue_rs1_idx_i == cdb_data_i.rob_idx)) begin
                            entry_d[i].rs1_ready = 1'b1;
                            entry_d[i].rs1_value = cdb_data_i.value;
                        end
                        if (!issue_rs2_ready_i && cdb_valid_i &&
                            (issue_rs2_idx_i == cdb_data_i.rob_idx)) begin
                            entry_d[i].rs2_ready = 1'b1;
                            entry_d[i].rs2_value = cdb_data_i.value;
                        end
                        entry_d[i].result        = '0;
                        entry_d[i].except_raised = 1'b0;
                        entry_d[i].state = (entry_d[i].rs1_ready && entry_d[i].rs2_ready)
                                           ? READY : WAIT_OPS;
                    end
                end
                WAIT_OPS: begin
                    if (cdb_valid_i && !entry_q[i].rs1_ready &&
                        (entry_q[i].rs1_idx == cdb_data_i.rob_idx)) begin
                        entry_d[i].rs1_ready = 1'b1;
                        entry_d[i].rs1_value = cdb_data_i.value;
                    end
                    if (cdb_valid_i && !entry_q[i].rs2_ready &&
                        (entry_q[i].rs2_idx == cdb_data_i.rob_idx)) begin
                        entry_d[i].rs2_ready = 1'b1;
                        entry_d[i].rs2_value = cdb_data_i.value;
                    end
                    if (entry_d[i].rs1_ready && entry_d[i].rs2_ready) begin
                        entry_d[i].state = READY;
                    end
                end
                READY: begin
                    if (dispatch_fire && (ready_idx == TAG_W'(i))) begin
                        entry_d[i].state = EXEC;
                    end
                end
                EXEC: begin
                    if (eu_valid_i && (eu_tag_i == TAG_W'(i))) begin
                        entry_d[i].result        = eu_result_i;
                        entry_d[i].except_raised = eu_except_raised_i;
                        entry_d[i].state         = DONE;
                    end
                end
                DONE: begin
                    if (grant_fire && (done_idx == TAG_W'(i))) begin
                        entry_d[i].state = EMPTY;
                    end
                end
                default: begin
                    entry_d[i].state = EMPTY;
                end
            endcase
            if (flush_i) begin
                entry_d[i].state = EMPTY;
            end
        end
    end

    // Entry storage; reset empties every entry immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_rs.sv
// Self-checking bench for cdb_rs: directed scenarios followed by random traffic,
// every cycle compared against a slot-level behavioural model.
module tb_cdb_rs;

   import len5_pkg::*;
   import expipe_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 2;

   logic                   clk;
   logic                   rst;
   logic                   flush;
   logic                   issueValid;
   logic                   issueReady;
   logic [EU_CTL_LEN-1:0]  issueCtl;
   logic                   rs1Ready;
   logic [ROB_IDX_LEN-1:0] rs1Idx;
   logic [XLEN-1:0]        rs1Value;
   logic                   rs2Ready;
   logic [ROB_IDX_LEN-1:0] rs2Idx;
   logic [XLEN-1:0]        rs2Value;
   logic [ROB_IDX_LEN-1:0] destIdx;
   logic                   euValidOut;
   logic                   euReadyIn;
   logic [EU_CTL_LEN-1:0]  euCtl;
   logic [XLEN-1:0]        euRs1;
   logic [XLEN-1:0]        euRs2;
   logic [TAG_W-1:0]       euTagOut;
   logic                   euValidIn;
   logic                   euReadyOut;
   logic [TAG_W-1:0]       euTagIn;
   logic [XLEN-1:0]        euResult;
   logic                   euExcept;
   logic                   cdbValidOut;
   logic                   cdbReady;
   cdb_data_t              cdbDataOut;
   logic                   cdbValidIn;
   cdb_data_t              cdbDataIn;

   int nChecks = 0;
   int nFail   = 0;

   // Model: each slot is either free or holds an instruction that may be waiting,
   // sent to the EU, or finished with a result.
   bit                     mUsed [DEPTH];
   bit                     mSent [DEPTH];
   bit                     mDone [DEPTH];
   bit                     mKnown1 [DEPTH];
   bit                     mKnown2 [DEPTH];
   logic [ROB_IDX_LEN-1:0] mWait1 [DEPTH];
   logic [ROB_IDX_LEN-1:0] mWait2 [DEPTH];
   logic [XLEN-1:0]        mVal1 [DEPTH];
   logic [XLEN-1:0]        mVal2 [DEPTH];
   logic [EU_CTL_LEN-1:0]  mCtl [DEPTH];
   logic [ROB_IDX_LEN-1:0] mDest [DEPTH];
   logic [XLEN-1:0]        mRes [DEPTH];
   bit                     mExc [DEPTH];

   cdb_rs #(.DEPTH(DEPTH)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .flush_i            (flush),
      .issue_valid_i      (issueValid),
      .issue_ready_o      (issueReady),
      .issue_eu_ctl_i     (issueCtl),
      .issue_rs1_ready_i  (rs1Ready),
      .issue_rs1_idx_i    (rs1Idx),
      .issue_rs1_value_i  (rs1Value),
      .issue_rs2_ready_i  (rs2Ready),
      .issue_rs2_idx_i    (rs2Idx),
      .issue_rs2_value_i  (rs2Value),
      .issue_dest_idx_i   (destIdx),
      .eu_valid_o         (euValidOut),
      .eu_ready_i         (euReadyIn),
      .eu_ctl_o           (euCtl),
      .eu_rs1_o           (euRs1),
      .eu_rs2_o           (euRs2),
      .eu_tag_o           (euTagOut),
      .eu_valid_i         (euValidIn),
      .eu_ready_o         (euReadyOut),
      .eu_tag_i           (euTagIn),
      .eu_result_i        (euResult),
      .eu_except_raised_i (euExcept),
      .cdb_valid_o        (cdbValidOut),
      .cdb_ready_i        (cdbReady),
      .cdb_data_o         (cdbDataOut),
      .cdb_valid_i        (cdbValidIn),
      .cdb_data_i         (cdbDataIn)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      nChecks++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clearSlot(input int i);
      mUsed[i]   = 1'b0;
      mSent[i]   = 1'b0;
      mDone[i]   = 1'b0;
      mKnown1[i] = 1'b0;
      mKnown2[i] = 1'b0;
   endtask

   task automatic modelReset();
      for (int i = 0; i < DEPTH; i++) clearSlot(i);
   endtask

   task automatic idleInputs();
      flush      = 1'b0;
      issueValid = 1'b0;
      issueCtl   = '0;
      rs1Ready   = 1'b0;
      rs1Idx     = '0;
      rs1Value   = '0;
      rs2Ready   = 1'b0;
      rs2Idx     = '0;
      rs2Value   = '0;
      destIdx    = '0;
      euReadyIn  = 1'b0;
      euValidIn  = 1'b0;
      euTagIn    = '0;
      euResult   = '0;
      euExcept   = 1'b0;
      cdbReady   = 1'b0;
      cdbValidIn = 1'b0;
      cdbDataIn  = '0;
   endtask

   task automatic setIssue(input logic [7:0] ctl, input logic r1, input logic [3:0] i1,
                           input logic [31:0] v1, input logic r2, input logic [3:0] i2,
                           input logic [31:0] v2, input logic [3:0] dest);
      issueValid = 1'b1;
      issueCtl   = ctl;
      rs1Ready   = r1;
      rs1Idx     = i1;
      rs1Value   = v1;
      rs2Ready   = r2;
      rs2Idx     = i2;
      rs2Value   = v2;
      destIdx    = dest;
   endtask

   // Return a result for the lowest slot the model believes is executing.
   task automatic driveAutoResult();
      euValidIn = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (mUsed[i] && mSent[i] && !mDone[i]) begin
            euValidIn = 1'b1;
            euTagIn   = TAG_W'(i);
         end
      end
      euResult = $urandom;
      euExcept = 1'($urandom % 2);
   endtask

   // One clock cycle: compare outputs with the model at the falling edge, advance
   // the model with the current inputs, then let the DUT take the rising edge.
   task automatic applyStimulus();
      int  fi;
      int  ri;
      int  di;
      int  tg;
      bit  resOk;
      @(negedge clk);
      fi = -1;
      ri = -1;
      di = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (!mUsed[i] && fi < 0) fi = i;
         if (mUsed[i] && !mSent[i] && mKnown1[i] && mKnown2[i] && ri < 0) ri = i;
         if (mDone[i] && di < 0) di = i;
      end
      checkOutput("issue_ready", 64'(issueReady), 64'(fi >= 0));
      checkOutput("eu_valid", 64'(euValidOut), 64'(ri >= 0));
      checkOutput("cdb_valid", 64'(cdbValidOut), 64'(di >= 0));
      checkOutput("eu_ready", 64'(euReadyOut), 64'd1);
      if (ri >= 0) begin
         checkOutput("eu_tag", 64'(euTagOut), 64'(ri));
         checkOutput("eu_ctl", 64'(euCtl), 64'(mCtl[ri]));
         checkOutput("eu_rs1", 64'(euRs1), 64'(mVal1[ri]));
         checkOutput("eu_rs2", 64'(euRs2), 64'(mVal2[ri]));
      end
      if (di >= 0) begin
         checkOutput("cdb_rob_idx", 64'(cdbDataOut.rob_idx), 64'(mDest[di]));
         checkOutput("cdb_value", 64'(cdbDataOut.value), 64'(mRes[di]));
         checkOutput("cdb_except", 64'(cdbDataOut.except_raised), 64'(mExc[di]));
      end
      if (flush) begin
         modelReset();
      end else begin
         tg    = int'(euTagIn);
         resOk = euValidIn && mUsed[tg] && mSent[tg] && !mDone[tg];
         if (ri >= 0 && euReadyIn) mSent[ri] = 1'b1;
         if (resOk) begin
            mDone[tg] = 1'b1;
            mRes[tg]  = euResult;
            mExc[tg]  = euExcept;
         end
         if (di >= 0 && cdbReady) clearSlot(di);
         if (cdbValidIn) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (mUsed[i] && !mSent[i]) begin
                  if (!mKnown1[i] && mWait1[i] == cdbDataIn.rob_idx) begin
                     mKnown1[i] = 1'b1;
                     mVal1[i]   = cdbDataIn.value;
                  end
                  if (!mKnown2[i] && mWait2[i] == cdbDataIn.rob_idx) begin
                     mKnown2[i] = 1'b1;
                     mVal2[i]   = cdbDataIn.value;
                  end
               end
            end
         end
         if (issueValid && fi >= 0) begin
            mUsed[fi]   = 1'b1;
            mSent[fi]   = 1'b0;
            mDone[fi]   = 1'b0;
            mCtl[fi]    = issueCtl;
            mDest[fi]   = destIdx;
            mWait1[fi]  = rs1Idx;
            mWait2[fi]  = rs2Idx;
            mKnown1[fi] = rs1Ready || (cdbValidIn && cdbDataIn.rob_idx == rs1Idx);
            mKnown2[fi] = rs2Ready || (cdbValidIn && cdbDataIn.rob_idx == rs2Idx);
            mVal1[fi]   = rs1Ready ? rs1Value : cdbDataIn.value;
            mVal2[fi]   = rs2Ready ? rs2Value : cdbDataIn.value;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Let the EU and the arbiter accept everything until the station empties.
   task automatic drainAll(input int cycles);
      repeat (cycles) begin
         idleInputs();
         euReadyIn = 1'b1;
         cdbReady  = 1'b1;
         driveAutoResult();
         applyStimulus();
      end
      idleInputs();
   endtask

   // Directed scenarios, then randomized traffic, then the summary.
   initial begin
      $display("[TB] cdb_rs bench starting");
      idleInputs();
      modelReset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_issue_ready", 64'(issueReady), 64'd1);
      checkOutput("rst_eu_valid", 64'(euValidOut), 64'd0);
      checkOutput("rst_cdb_valid", 64'(cdbValidOut), 64'd0);
      checkOutput("rst_eu_ready", 64'(euReadyOut), 64'd1);

      // Scenario 1: single instruction through the whole life cycle.
      setIssue(8'h11, 1'b1, 4'd0, 32'h100, 1'b1, 4'd0, 32'h200, 4'd5);
      applyStimulus();
      idleInputs();
      checkOutput("s1_eu_valid", 64'(euValidOut), 64'd1);
      checkOutput("s1_eu_tag", 64'(euTagOut), 64'd0);
      euReadyIn = 1'b1;
      applyStimulus();
      idleInputs();
      euValidIn = 1'b1;
      euTagIn   = 2'd0;
      euResult  = 32'hAB;
      applyStimulus();
      idleInputs();
      checkOutput("s1_cdb_valid", 64'(cdbValidOut), 64'd1);
      checkOutput("s1_cdb_data", 64'(cdbDataOut), 64'({4'd5, 32'hAB, 1'b0}));
      cdbReady = 1'b1;
      applyStimulus();
      idleInputs();
      checkOutput("s1_freed_cdb_valid", 64'(cdbValidOut), 64'd0);

      // Scenario 2: rs1 captured from a later broadcast.
      setIssue(8'h22, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'h2222, 4'd6);
      applyStimulus();
      idleInputs();
      checkOutput("s2_waiting", 64'(euValidOut), 64'd0);
      repeat (2) applyStimulus();
      cdbValidIn = 1'b1;
      cdbDataIn  = '{rob_idx: 4'd7, value: 32'h1234, except_raised: 1'b0};
      applyStimulus();
      idleInputs();
      checkOutput("s2_eu_valid", 64'(euValidOut), 64'd1);
      checkOutput("s2_eu_rs1", 64'(euRs1), 64'h1234);
      drainAll(6);

      // Scenario 3: rs2 forwarded from the broadcast in the issue cycle.
      setIssue(8'h33, 1'b1, 4'd0, 32'h3131, 1'b0, 4'd3, 32'h0, 4'd8);
      cdbValidIn = 1'b1;
      cdbDataIn  = '{rob_idx: 4'd3, value: 32'h5555, except_raised: 1'b1};
      applyStimulus();
      idleInputs();
      checkOutput("s3_eu_valid", 64'(euValidOut), 64'd1);
      checkOutput("s3_eu_rs2", 64'(euRs2), 64'h5555);
      drainAll(6);

      // Scenario 4: fill, free entry 2, refill entry 2.
      for (int k = 0; k < DEPTH; k++) begin
         setIssue(8'(8'h40 + k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'(k + 100), 4'(k + 1));
         applyStimulus();
      end
      idleInputs();
      checkOutput("s4_full", 64'(issueReady), 64'd0);
      euReadyIn = 1'b1;
      repeat (DEPTH) applyStimulus();
      idleInputs();
      euValidIn = 1'b1;
      euTagIn   = 2'd2;
      euResult  = 32'h22;
      applyStimulus();
      idleInputs();
      cdbReady = 1'b1;
      applyStimulus();
      idleInputs();
      checkOutput("s4_reopened", 64'(issueReady), 64'd1);
      setIssue(8'h4F, 1'b1, 4'd0, 32'h4F4F, 1'b1, 4'd0, 32'h4E4E, 4'd9);
      applyStimulus();
      idleInputs();
      checkOutput("s4_refill_valid", 64'(euValidOut), 64'd1);
      checkOutput("s4_refill_tag", 64'(euTagOut), 64'd2);
      drainAll(14);

      // Scenario 5: two finished entries held by a busy arbiter.
      setIssue(8'h50, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2, 4'd10);
      applyStimulus();
      setIssue(8'h51, 1'b1, 4'd0, 32'h3, 1'b1, 4'd0, 32'h4, 4'd11);
      applyStimulus();
      idleInputs();
      euReadyIn = 1'b1;
      repeat (2) applyStimulus();
      idleInputs();
      euValidIn = 1'b1;
      euTagIn   = 2'd0;
      euResult  = 32'hA0;
      applyStimulus();
      euTagIn   = 2'd1;
      euResult  = 32'hA1;
      applyStimulus();
      idleInputs();
      repeat (5) begin
         applyStimulus();
         checkOutput("s5_hold_idx", 64'(cdbDataOut.rob_idx), 64'd10);
         checkOutput("s5_hold_value", 64'(cdbDataOut.value), 64'hA0);
      end
      cdbReady = 1'b1;
      applyStimulus();
      checkOutput("s5_second_idx", 64'(cdbDataOut.rob_idx), 64'd11);
      applyStimulus();
      idleInputs();
      checkOutput("s5_drained", 64'(cdbValidOut), 64'd0);

      // Scenario 6: flush with work in the EU, then a stale result.
      setIssue(8'h60, 1'b1, 4'd0, 32'h6, 1'b1, 4'd0, 32'h7, 4'd12);
      applyStimulus();
      setIssue(8'h61, 1'b1, 4'd0, 32'h8, 1'b1, 4'd0, 32'h9, 4'd13);
      applyStimulus();
      idleInputs();
      euReadyIn = 1'b1;
      repeat (2) applyStimulus();
      idleInputs();
      flush = 1'b1;
      applyStimulus();
      idleInputs();
      euValidIn = 1'b1;
      euTagIn   = 2'd1;
      euResult  = 32'hDEAD;
      applyStimulus();
      idleInputs();
      checkOutput("s6_stale_cdb_valid", 64'(cdbValidOut), 64'd0);
      checkOutput("s6_issue_ready", 64'(issueReady), 64'd1);

      // Asynchronous reset while an instruction is waiting for dispatch.
      setIssue(8'h70, 1'b1, 4'd0, 32'h70, 1'b1, 4'd0, 32'h71, 4'd14);
      applyStimulus();
      idleInputs();
      checkOutput("s6_pre_reset_valid", 64'(euValidOut), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("s6_async_reset_eu_valid", 64'(euValidOut), 64'd0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Random traffic against the model.
      repeat (600) begin
         issueValid = (($urandom % 3) != 0);
         issueCtl   = 8'($urandom);
         rs1Ready   = 1'($urandom % 2);
         rs1Idx     = 4'($urandom % 8);
         rs1Value   = $urandom;
         rs2Ready   = 1'($urandom % 2);
         rs2Idx     = 4'($urandom % 8);
         rs2Value   = $urandom;
         destIdx    = 4'($urandom);
         cdbValidIn = 1'($urandom % 2);
         cdbDataIn.rob_idx       = 4'($urandom % 8);
         cdbDataIn.value         = $urandom;
         cdbDataIn.except_raised = 1'($urandom % 2);
         euReadyIn  = 1'($urandom % 2);
         if (($urandom % 4) != 0) begin
            driveAutoResult();
         end else begin
            euValidIn = 1'($urandom % 2);
            euTagIn   = 2'($urandom);
            euResult  = $urandom;
            euExcept  = 1'($urandom % 2);
         end
         cdbReady = 1'($urandom % 2);
         flush    = (($urandom % 40) == 0);
         applyStimulus();
      end
      idleInputs();
      drainAll(12);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
